// File: rtl/main_memory.sv
// Latency-modelled backing store answering data_cache line fills (multi-beat) and word writes.
// Define MAIN_MEM_CRITICAL_WORD_FIRST_EN to return fill beats starting at the requested word.
module main_memory #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned LATENCY     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  req_ready_o,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_data_o,
  output logic                  rsp_last_o
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned OffW = $clog2(LINE_WORDS);
  localparam int unsigned CntW = $clog2(LATENCY + 1);

  // The write commit has no cycle of its own: it happens on the edge that leaves StWait.
  typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

  state_e            state_q;
  logic              ready_q;
  logic              valid_q;
  logic              last_q;
  logic [31:0]       data_q;
  logic [CntW-1:0]   cnt_q;
  logic [OffW-1:0]   beat_q;
  logic [IdxW-1:0]   idx_q;
  logic              write_q;
  logic [31:0]       wdata_q;

  // Not reset; relies on power-on zero contents of the storage.
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic [OffW-1:0]   lane;
  logic [IdxW-1:0]   rd_idx;
  logic              mem_we;
  logic              unused_addr;

  assign unused_addr = ^{req_addr_i[ADDR_WIDTH-1:IdxW+2], req_addr_i[1:0]};

  always_comb begin
    lane = beat_q;
`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
    lane = idx_q[OffW-1:0] + beat_q;
`endif
    rd_idx = {idx_q[IdxW-1:OffW], lane};
  end

  assign mem_we = !rst_i && (state_q == StWait) && (cnt_q == '0) && write_q;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (req_valid_i && ready_q) begin
            state_q <= StWait;
            ready_q <= 1'b0;
            cnt_q   <= CntW'(LATENCY - 1);
            beat_q  <= '0;
            idx_q   <= req_addr_i[IdxW+1:2];
            write_q <= req_write_i;
            wdata_q <= req_wdata_i;
          end
        end
        StWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (write_q) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end else begin
            state_q <= StBurst;
            valid_q <= 1'b1;
            data_q  <= mem_q[rd_idx];
            beat_q  <= beat_q + 1'b1;
          end
        end
        StBurst: begin
          if (last_q) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
          end else begin
            data_q <= mem_q[rd_idx];
            last_q <= (beat_q == OffW'(LINE_WORDS - 1));
            beat_q <= beat_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = valid_q;
  assign rsp_data_o  = data_q;
  assign rsp_last_o  = last_q;

endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: reset, write/fill timing, beat order, address wrap, aborts.
module tb_main_memory;

  localparam int L  = 8;
  localparam int LW = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_last;

  int checks = 0;
  int failures = 0;

  main_memory #(
    .ADDR_WIDTH (32),
    .DEPTH_WORDS(1024),
    .LINE_WORDS (LW),
    .LATENCY    (L)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_write_i(req_write),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid),
    .rsp_data_o (rsp_data),
    .rsp_last_o (rsp_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a word write in a cycle where req_ready is high; returns in cycle 0.
  task automatic send_write(input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    tick();
    req_valid = 1'b0;
  endtask

  // Issue a fill and record cycles 0..L+LW; returns in cycle L+LW.
  task automatic capture_fill(input logic [31:0] addr, output logic [15:0] vmask,
                              output logic [15:0] lmask, output logic [LW-1:0][31:0] beats,
                              output logic stray, output logic busy_bad, output logic rdy_end);
    int n;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    req_wdata = 32'hFFFF_FFFF;
    tick();
    req_valid = 1'b0;
    n = 0;
    vmask = '0;
    lmask = '0;
    beats = '0;
    stray = 1'b0;
    busy_bad = 1'b0;
    rdy_end = 1'b0;
    for (int c = 0; c <= L + LW; c++) begin
      vmask[c] = rsp_valid;
      lmask[c] = rsp_last;
      if (rsp_valid && n < LW) begin
        beats[n] = rsp_data;
        n++;
      end else if (!rsp_valid && rsp_data != 32'h0) begin
        stray = 1'b1;
      end
      if (c < L + LW) begin
        if (req_ready) busy_bad = 1'b1;
        tick();
      end else begin
        rdy_end = req_ready;
      end
    end
  endtask

  task automatic test_reset();
    logic bad;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b want=0", req_ready);
    end
    checks++;
    if ({rsp_valid, rsp_last, rsp_data} !== 34'h0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b last=%b data=%h want 0", rsp_valid, rsp_last,
               rsp_data);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_ready got=%b want=1", req_ready);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL idle_quiet got=%b want=0", bad);
    end
  endtask

  task automatic test_write_then_fill();
    logic bad;
    logic [15:0] vm, lm;
    logic [LW-1:0][31:0] bt;
    logic st, bb, re;
    send_write(32'h4, 32'h7);
    // A request presented while busy must be ignored.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'hC;
    req_wdata = 32'hDEAD;
    bad = 1'b0;
    for (int c = 0; c < L; c++) begin
      if (c == L - 1) req_valid = 1'b0;
      if (req_ready !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL write_busy_ready got=%b want=0", bad);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL write_ready_cycle8 got=%b want=1", req_ready);
    end
    capture_fill(32'h0, vm, lm, bt, st, bb, re);
    checks++;
    if (vm !== 16'h0F00) begin
      failures++;
      $display("FAIL fill_valid_cycles got=%h want=0f00", vm);
    end
    checks++;
    if (lm !== 16'h0800) begin
      failures++;
      $display("FAIL fill_last_cycle got=%h want=0800", lm);
    end
    checks++;
    if (bt !== {32'h0, 32'h0, 32'h7, 32'h0}) begin
      failures++;
      $display("FAIL fill_data got=%h,%h,%h,%h want=0,7,0,0", bt[0], bt[1], bt[2], bt[3]);
    end
    checks++;
    if ({st, bb, re} !== 3'b001) begin
      failures++;
      $display("FAIL fill_handshake got stray=%b busy=%b ready_end=%b want 0,0,1", st, bb, re);
    end
  endtask

  task automatic test_critical_word();
    logic [15:0] vm, lm;
    logic [LW-1:0][31:0] bt;
    logic [LW-1:0][31:0] exp;
    logic st, bb, re;
    send_write(32'h20, 32'h3);
    for (int c = 0; c < L; c++) tick();
`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
    exp = {32'h0, 32'h0, 32'h3, 32'h0};
`else
    exp = {32'h0, 32'h0, 32'h0, 32'h3};
`endif
    capture_fill(32'h2C, vm, lm, bt, st, bb, re);
    checks++;
    if (bt !== exp) begin
      failures++;
      $display("FAIL beat_order got=%h,%h,%h,%h want=%h,%h,%h,%h", bt[0], bt[1], bt[2], bt[3],
               exp[0], exp[1], exp[2], exp[3]);
    end
    checks++;
    if (vm !== 16'h0F00 || lm !== 16'h0800) begin
      failures++;
      $display("FAIL offset_fill_timing got valid=%h last=%h want 0f00/0800", vm, lm);
    end
  endtask

  task automatic test_addr_wrap();
    logic [15:0] vm, lm;
    logic [LW-1:0][31:0] bt;
    logic st, bb, re;
    send_write(32'd1024 * 4 + 32'h8, 32'hA5);
    for (int c = 0; c < L; c++) tick();
    capture_fill(32'h0, vm, lm, bt, st, bb, re);
    checks++;
    if (bt !== {32'h0, 32'hA5, 32'h7, 32'h0}) begin
      failures++;
      $display("FAIL addr_wrap got=%h,%h,%h,%h want=0,7,a5,0", bt[0], bt[1], bt[2], bt[3]);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic bad;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < L + 1; c++) tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h7) begin
      failures++;
      $display("FAIL second_beat got valid=%b data=%h want 1/00000007", rsp_valid, rsp_data);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_fill got valid=%b ready=%b want 0/0", rsp_valid, req_ready);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_abort got=%b want=1", req_ready);
    end
    bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL beats_after_abort got=%b want=0", bad);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] vm, lm;
    logic [LW-1:0][31:0] bt;
    logic st, bb, re;
    send_write(32'h10, 32'h55);
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    capture_fill(32'h10, vm, lm, bt, st, bb, re);
    checks++;
    if (bt !== {32'h0, 32'h0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL discarded_write got=%h,%h,%h,%h want=0,0,0,0", bt[0], bt[1], bt[2], bt[3]);
    end
    checks++;
    if (vm !== 16'h0F00) begin
      failures++;
      $display("FAIL fill_after_abort got=%h want=0f00", vm);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    test_reset();
    test_write_then_fill();
    test_critical_word();
    test_addr_wrap();
    test_reset_mid_fill();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
